outlet_collector: RTL and testbench

- Digital controller at the outlet end of a synthetic flow netlist: runs one assay cycle per start request.
- Waits a fixed transit time for fluid to reach the Out port, then samples the outlet detector.
- Routes the fluid plug to a collection well (pass) or to waste (fail), and reports the result to the host through a valid/ready handshake.
- Sits between the netlist's Out port and the host sequencer. It is the consumer side of the Source→Out flow path.

---
 rtl/outlet_collector_pkg.sv | 23 ++
 rtl/outlet_collector_if.sv | 38 +++
 rtl/outlet_collector_cycle_timer.sv | 27 ++
 rtl/outlet_collector.sv | 147 ++++++++++++++
 tb/tb_outlet_collector.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/outlet_collector_pkg.sv
// Shared types and width helpers for the outlet collector.
package outlet_collector_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTransit,
    StSample,
    StDispense,
    StResult
  } state_e;

  // Width of an index over n items, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width: summing n_samples values of data_w bits cannot overflow.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned n_samples);
    return data_w + $clog2(n_samples);
  endfunction

endpackage

// File: rtl/outlet_collector_if.sv
// Host/detector/valve signal bundle for the outlet collector.
interface outlet_collector_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_WELLS = 4
) ();
  import outlet_collector_pkg::*;

  localparam int unsigned WELL_W = clog2_min1(NUM_WELLS);

  logic              start;
  logic              abort;
  logic              clear_wells;
  logic              det_valid;
  logic [DATA_W-1:0] det_data;
  logic              valve_collect;
  logic              valve_waste;
  logic [WELL_W-1:0] well_sel;
  logic              busy;
  logic              wells_full;
  logic              result_valid;
  logic              result_ready;
  logic              result_pass;
  logic [DATA_W-1:0] result_avg;
  logic [WELL_W-1:0] result_well;

  modport master (
    output start, abort, clear_wells, det_valid, det_data, result_ready,
    input  valve_collect, valve_waste, well_sel, busy, wells_full,
    input  result_valid, result_pass, result_avg, result_well
  );

  modport slave (
    input  start, abort, clear_wells, det_valid, det_data, result_ready,
    output valve_collect, valve_waste, well_sel, busy, wells_full,
    output result_valid, result_pass, result_avg, result_well
  );

endinterface

// File: rtl/outlet_collector_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/outlet_collector.sv
// Outlet-end assay controller: transit wait, detector averaging, valve routing
// to a collection well or waste, and a valid/ready result to the host.
module outlet_collector
  import outlet_collector_pkg::*;
#(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned N_SAMPLES       = 4,
  parameter int unsigned TRANSIT_CYCLES  = 64,
  parameter int unsigned DISPENSE_CYCLES = 16,
  parameter int unsigned NUM_WELLS       = 4,
  parameter int unsigned THRESHOLD       = 128
) (
  input logic               clk,
  input logic               rst_n,
  outlet_collector_if.slave bus
);

  localparam int unsigned WELL_W = clog2_min1(NUM_WELLS);
  localparam int unsigned ACC_W  = acc_width(DATA_W, N_SAMPLES);
  localparam int unsigned SHIFT  = $clog2(N_SAMPLES);
  localparam int unsigned SCNT_W = clog2_min1(N_SAMPLES);
  localparam int unsigned TMAX   = (TRANSIT_CYCLES > DISPENSE_CYCLES) ?
                                   TRANSIT_CYCLES : DISPENSE_CYCLES;
  localparam int unsigned TMR_W  = clog2_min1(TMAX);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_sum;
  logic [SCNT_W-1:0] scnt_q;
  logic [WELL_W-1:0] ptr_q, rwell_q;
  logic              full_q, pass_q;
  logic [DATA_W-1:0] avg_q, avg_new;
  logic              pass_new, abort_act, start_ok, sample_take, sample_last;
  logic              tmr_load, tmr_en, tmr_done;
  logic [TMR_W-1:0]  tmr_val;

  assign abort_act   = bus.abort && (state_q != StIdle);
  // A same-cycle clear frees the wells before start is judged.
  assign start_ok    = bus.start && (!full_q || bus.clear_wells);
  assign sample_take = (state_q == StSample) && bus.det_valid;
  assign sample_last = sample_take && (scnt_q == SCNT_W'(N_SAMPLES - 1));
  assign acc_sum     = acc_q + ACC_W'(bus.det_data);
  assign avg_new     = DATA_W'(acc_sum >> SHIFT);
  assign pass_new    = (32'(avg_new) >= THRESHOLD);

  // Timer is reloaded on entry to TRANSIT or DISPENSE so it runs N-1 down to 0.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (abort_act) begin
      tmr_load = 1'b1;
    end else if ((state_q == StIdle) && start_ok) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(TRANSIT_CYCLES - 1);
    end else if (sample_last) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(DISPENSE_CYCLES - 1);
    end
  end

  assign tmr_en = (state_q == StTransit) || (state_q == StDispense);

  cycle_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start_ok)         state_d = StTransit;
      StTransit:  if (tmr_done)         state_d = StSample;
      StSample:   if (sample_last)      state_d = StDispense;
      StDispense: if (tmr_done)         state_d = StResult;
      StResult:   if (bus.result_ready) state_d = StIdle;
      default:                          state_d = StIdle;
    endcase
    if (abort_act) state_d = StIdle;
  end

  always_comb begin
    bus.busy          = (state_q != StIdle);
    bus.valve_collect = (state_q == StDispense) && pass_q;
    bus.valve_waste   = (state_q == StDispense) && !pass_q;
    bus.well_sel      = ((state_q == StDispense) && pass_q) ? ptr_q : '0;
    bus.result_valid  = (state_q == StResult);
    bus.wells_full    = full_q;
    bus.result_pass   = pass_q;
    bus.result_avg    = avg_q;
    bus.result_well   = rwell_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      scnt_q  <= '0;
      ptr_q   <= '0;
      full_q  <= 1'b0;
      pass_q  <= 1'b0;
      avg_q   <= '0;
      rwell_q <= '0;
    end else if (abort_act) begin
      acc_q  <= '0;
      scnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.clear_wells) begin
            ptr_q  <= '0;
            full_q <= 1'b0;
          end
        end
        StSample: begin
          if (sample_last) begin
            acc_q   <= '0;
            scnt_q  <= '0;
            avg_q   <= avg_new;
            pass_q  <= pass_new;
            rwell_q <= pass_new ? ptr_q : '0;
          end else if (sample_take) begin
            acc_q  <= acc_sum;
            scnt_q <= scnt_q + SCNT_W'(1);
          end
        end
        StDispense: begin
          // Pointer parks on the last well once every well has been used.
          if (tmr_done && pass_q) begin
            if (ptr_q == WELL_W'(NUM_WELLS - 1)) full_q <= 1'b1;
            else                                  ptr_q  <= ptr_q + WELL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_outlet_collector.sv
// Directed self-checking bench for outlet_collector with default parameters.
module tb_outlet_collector;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   nc, nw, bad;

  outlet_collector_if #(.DATA_W(8), .NUM_WELLS(4)) bus ();

  outlet_collector #(
    .DATA_W          (8),
    .N_SAMPLES       (4),
    .TRANSIT_CYCLES  (64),
    .DISPENSE_CYCLES (16),
    .NUM_WELLS       (4),
    .THRESHOLD       (128)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a cycle (optionally with clear_wells), optionally spam det_valid with
  // 255 through TRANSIT, then feed four samples separated by gap idle cycles.
  task automatic run_to_dispense(input logic clr, input logic junk,
                                 input logic [7:0] s0, input logic [7:0] s1,
                                 input logic [7:0] s2, input logic [7:0] s3,
                                 input int gap);
    logic [7:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    bus.clear_wells = clr;
    bus.start       = 1'b1;
    step();
    bus.clear_wells = 1'b0;
    bus.start       = 1'b0;
    bus.det_valid   = junk;
    bus.det_data    = 8'hff;
    repeat (64) step();
    for (int i = 0; i < 4; i++) begin
      bus.det_valid = 1'b1;
      bus.det_data  = s[i];
      step();
      bus.det_valid = 1'b0;
      bus.det_data  = 8'hff;
      if (i < 3) repeat (gap) step();
    end
  endtask

  task automatic measure_dispense(input logic [1:0] exp_sel, output int n_col,
                                  output int n_wst, output int n_bad);
    n_col = 0; n_wst = 0; n_bad = 0;
    for (int g = 0; g < 40 && (bus.valve_collect || bus.valve_waste); g++) begin
      if (bus.valve_collect) n_col++;
      if (bus.valve_waste) n_wst++;
      if (bus.well_sel !== (bus.valve_collect ? exp_sel : 2'd0)) n_bad++;
      step();
    end
  endtask

  task automatic handshake();
    for (int g = 0; g < 5 && !bus.result_valid; g++) step();
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.busy, bus.valve_collect, bus.valve_waste, bus.result_valid, bus.wells_full,
         bus.result_pass} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000", {bus.busy, bus.valve_collect,
               bus.valve_waste, bus.result_valid, bus.wells_full, bus.result_pass});
    end
    checks++;
    if (bus.result_avg !== 8'd0) begin
      errors++; $display("FAIL reset_avg: got %0d expected 0", bus.result_avg);
    end
    checks++;
    if ({bus.well_sel, bus.result_well} !== 4'd0) begin
      errors++; $display("FAIL reset_wells: got %b expected 0000", {bus.well_sel, bus.result_well});
    end
  endtask

  task automatic test_pass();
    run_to_dispense(1'b0, 1'b0, 8'd200, 8'd200, 8'd200, 8'd200, 0);
    measure_dispense(2'd0, nc, nw, bad);
    checks++;
    if (nc != 16 || nw != 0 || bad != 0) begin
      errors++; $display("FAIL pass_valves: got col=%0d wst=%0d bad=%0d expected 16 0 0", nc, nw, bad);
    end
    checks++;
    if ({bus.result_valid, bus.busy, bus.result_pass} !== 3'b111) begin
      errors++; $display("FAIL pass_flags: got %b expected 111",
                         {bus.result_valid, bus.busy, bus.result_pass});
    end
    checks++;
    if (bus.result_avg !== 8'd200 || bus.result_well !== 2'd0) begin
      errors++; $display("FAIL pass_result: got avg=%0d well=%0d expected 200 0",
                         bus.result_avg, bus.result_well);
    end
    repeat (3) step();
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_avg !== 8'd200) begin
      errors++; $display("FAIL pass_hold: got valid=%b avg=%0d expected 1 200",
                         bus.result_valid, bus.result_avg);
    end
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL pass_accept: got valid=%b busy=%b expected 0 0",
                         bus.result_valid, bus.busy);
    end
  endtask

  task automatic test_fail();
    run_to_dispense(1'b0, 1'b0, 8'd100, 8'd120, 8'd110, 8'd130, 0);
    measure_dispense(2'd0, nc, nw, bad);
    checks++;
    if (nc != 0 || nw != 16 || bad != 0) begin
      errors++; $display("FAIL fail_valves: got col=%0d wst=%0d bad=%0d expected 0 16 0", nc, nw, bad);
    end
    checks++;
    if (bus.result_pass !== 1'b0 || bus.result_avg !== 8'd115 || bus.result_well !== 2'd0) begin
      errors++; $display("FAIL fail_result: got pass=%b avg=%0d well=%0d expected 0 115 0",
                         bus.result_pass, bus.result_avg, bus.result_well);
    end
    handshake();
    // Pointer was 1 before the failing cycle and must still be 1.
    run_to_dispense(1'b0, 1'b0, 8'd150, 8'd150, 8'd150, 8'd150, 0);
    measure_dispense(2'd1, nc, nw, bad);
    checks++;
    if (nc != 16 || bad != 0 || bus.result_well !== 2'd1) begin
      errors++; $display("FAIL fail_ptr_kept: got col=%0d bad=%0d well=%0d expected 16 0 1",
                         nc, bad, bus.result_well);
    end
    handshake();
  endtask

  task automatic test_threshold();
    run_to_dispense(1'b0, 1'b0, 8'd128, 8'd127, 8'd129, 8'd128, 0);
    measure_dispense(2'd2, nc, nw, bad);
    checks++;
    if (nc != 16 || bad != 0 || bus.result_pass !== 1'b1 || bus.result_avg !== 8'd128 ||
        bus.result_well !== 2'd2) begin
      errors++; $display("FAIL thr_equal: got col=%0d bad=%0d pass=%b avg=%0d well=%0d exp 16 0 1 128 2",
                         nc, bad, bus.result_pass, bus.result_avg, bus.result_well);
    end
    handshake();
    run_to_dispense(1'b0, 1'b0, 8'd127, 8'd128, 8'd127, 8'd128, 0);
    measure_dispense(2'd0, nc, nw, bad);
    checks++;
    if (nw != 16 || bus.result_pass !== 1'b0 || bus.result_avg !== 8'd127) begin
      errors++; $display("FAIL thr_below: got wst=%0d pass=%b avg=%0d expected 16 0 127",
                         nw, bus.result_pass, bus.result_avg);
    end
    handshake();
  endtask

  task automatic test_fill();
    logic [7:0] v;
    bus.clear_wells = 1'b1;
    step();
    bus.clear_wells = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v = 8'(140 + 20 * k);
      run_to_dispense(1'b0, 1'b0, v, v, v, v, 0);
      measure_dispense(2'(k), nc, nw, bad);
      checks++;
      if (nc != 16 || bad != 0 || bus.result_well !== 2'(k) || bus.result_avg !== v ||
          bus.wells_full !== (k == 3)) begin
        errors++; $display("FAIL fill_%0d: got col=%0d bad=%0d well=%0d avg=%0d full=%b", k, nc,
                           bad, bus.result_well, bus.result_avg, bus.wells_full);
      end
      handshake();
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL full_start_ignored: got busy=%b expected 0", bus.busy);
    end
    repeat (3) step();
    checks++;
    if (bus.busy !== 1'b0 || bus.wells_full !== 1'b1) begin
      errors++; $display("FAIL full_hold: got busy=%b full=%b expected 0 1", bus.busy, bus.wells_full);
    end
    run_to_dispense(1'b1, 1'b0, 8'd200, 8'd200, 8'd200, 8'd200, 0);
    measure_dispense(2'd0, nc, nw, bad);
    checks++;
    if (nc != 16 || bad != 0 || bus.wells_full !== 1'b0 || bus.result_well !== 2'd0) begin
      errors++; $display("FAIL clear_start: got col=%0d bad=%0d full=%b well=%0d expected 16 0 0 0",
                         nc, bad, bus.wells_full, bus.result_well);
    end
    handshake();
  endtask

  task automatic test_transit_ignore();
    run_to_dispense(1'b0, 1'b1, 8'd60, 8'd70, 8'd80, 8'd90, 2);
    measure_dispense(2'd0, nc, nw, bad);
    checks++;
    if (nw != 16 || nc != 0 || bus.result_pass !== 1'b0 || bus.result_avg !== 8'd75) begin
      errors++; $display("FAIL transit_gap: got wst=%0d col=%0d pass=%b avg=%0d expected 16 0 0 75",
                         nw, nc, bus.result_pass, bus.result_avg);
    end
    handshake();
  endtask

  task automatic test_abort();
    run_to_dispense(1'b0, 1'b0, 8'd200, 8'd200, 8'd200, 8'd200, 0);
    repeat (9) step();
    checks++;
    if (bus.valve_collect !== 1'b1) begin
      errors++; $display("FAIL abort_pre: got collect=%b expected 1", bus.valve_collect);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    checks++;
    if ({bus.valve_collect, bus.valve_waste, bus.busy, bus.result_valid} !== 4'b0) begin
      errors++; $display("FAIL abort_stop: got %b expected 0000",
                         {bus.valve_collect, bus.valve_waste, bus.busy, bus.result_valid});
    end
    repeat (20) step();
    checks++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_result: got valid=%b busy=%b expected 0 0",
                         bus.result_valid, bus.busy);
    end
    run_to_dispense(1'b0, 1'b0, 8'd200, 8'd200, 8'd200, 8'd200, 0);
    measure_dispense(2'd1, nc, nw, bad);
    checks++;
    if (nc != 16 || bad != 0 || bus.result_well !== 2'd1) begin
      errors++; $display("FAIL abort_ptr_kept: got col=%0d bad=%0d well=%0d expected 16 0 1",
                         nc, bad, bus.result_well);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    run_to_dispense(1'b0, 1'b0, 8'd200, 8'd200, 8'd200, 8'd200, 0);
    repeat (3) step();
    checks++;
    if (bus.valve_collect !== 1'b1) begin
      errors++; $display("FAIL rst_pre: got collect=%b expected 1", bus.valve_collect);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.valve_collect, bus.valve_waste, bus.busy, bus.result_valid, bus.wells_full,
         bus.result_pass, bus.well_sel, bus.result_well, bus.result_avg} !== 18'd0) begin
      errors++; $display("FAIL rst_async: got collect=%b busy=%b avg=%0d sel=%0d expected all 0",
                         bus.valve_collect, bus.busy, bus.result_avg, bus.well_sel);
    end
    #10 rst_n = 1'b1;
    step();
    run_to_dispense(1'b0, 1'b0, 8'd180, 8'd180, 8'd180, 8'd180, 0);
    measure_dispense(2'd0, nc, nw, bad);
    checks++;
    if (nc != 16 || bad != 0 || bus.result_well !== 2'd0 || bus.result_avg !== 8'd180) begin
      errors++; $display("FAIL rst_rerun: got col=%0d bad=%0d well=%0d avg=%0d expected 16 0 0 180",
                         nc, bad, bus.result_well, bus.result_avg);
    end
    handshake();
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.clear_wells  = 1'b0;
    bus.det_valid    = 1'b0;
    bus.det_data     = 8'd0;
    bus.result_ready = 1'b0;
    #23 rst_n = 1'b1;
    step();
    test_reset();
    test_pass();
    test_fail();
    test_threshold();
    test_fill();
    test_transit_ignore();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
